matrix_add_pipe: RTL and testbench
==================================

MATRIX_ADD_PIPE -- requirements
Module: matrix_add_pipe

Interface
REQ-001 Parameter W, default 16, SHALL set the bit width of each lane element.
REQ-002 Parameter N, default 5, SHALL set the number of parallel lanes (N >= 1).
REQ-003 Parameter CW, default 16, SHALL set the width of the transfer counter.
REQ-004 clk  input  1  SHALL be the single clock; all logic SHALL be rising-edge triggered.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 in_valid  input  1  SHALL mean the upstream source presents an operand pair.
REQ-007 in_ready  output  1  SHALL mean the block accepts an operand pair this cycle.
REQ-008 a_vec  input  N*W  SHALL carry operand A; lane k SHALL occupy bits [k*W +: W], with lane N-1 most significant.
REQ-009 b_vec  input  N*W  SHALL carry operand B, with the same lane layout as a_vec.
REQ-010 sat_en  input  1  SHALL select unsigned saturation when 1 and wrap-around when 0; it is sampled with the operands.
REQ-011 out_valid  output  1  SHALL mean sum_vec and ovf hold a valid result.
REQ-012 out_ready  input  1  SHALL mean the downstream sink accepts the result this cycle.
REQ-013 sum_vec  output  N*W  SHALL carry the per-lane sums, using the same lane layout as the operands.
REQ-014 ovf  output  N  SHALL flag, in bit k, a carry-out from lane k.
REQ-015 xfer_cnt  output  CW  SHALL count completed output transfers.

Function
REQ-016 An input transfer SHALL occur in a cycle where in_valid && in_ready, sampled at the rising edge.
REQ-017 An output transfer SHALL occur in a cycle where out_valid && out_ready.
REQ-018 in_ready SHALL equal (!out_valid || out_ready) && !rst, which is combinational.
REQ-019 On an input transfer, each lane SHALL compute the W+1-bit sum a_k + b_k, and the block SHALL register the result so that out_valid rises in the next cycle (latency 1).
REQ-020 In each lane, ovf[k] SHALL be the carry bit (bit W) of the W+1-bit sum.
REQ-021 In wrap mode (sat_en=0), sum_k SHALL be the low W bits of the sum.
REQ-022 In saturate mode (sat_en=1), sum_k SHALL be all-ones when the carry is set, and the low W bits otherwise.
REQ-023 ovf SHALL report the carry in both modes.
REQ-024 Lanes SHALL be fully independent, with no carry propagating between lanes.
REQ-025 While out_valid=1 and out_ready=0, sum_vec, ovf and out_valid SHALL hold stable, and in_ready SHALL be 0.
REQ-026 On a simultaneous output transfer and input transfer, the new result SHALL load and out_valid SHALL stay 1, giving full throughput of one result per cycle with no bubble.
REQ-027 On an output transfer with no input transfer, out_valid SHALL drop to 0 in the next cycle.
REQ-028 xfer_cnt SHALL increment by 1 on each output transfer and SHALL wrap from 2^CW-1 to 0.
REQ-029 The control SHALL be a 2-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY to FULL on an input transfer.
- FULL to FULL on an output transfer with an input transfer, or on a stall.
- FULL to EMPTY on an output transfer without an input transfer.
REQ-030 When in_valid=0, the input data and sat_en SHALL be don't-care and SHALL NOT affect any state.

Reset
REQ-031 While rst=1 at a clock edge, out_valid SHALL be 0, sum_vec all zeros, ovf all zeros, xfer_cnt 0, and the state EMPTY.
REQ-032 in_ready SHALL be 0 while rst=1, and SHALL be 1 in the first cycle after rst deasserts.
REQ-033 A reset asserted mid-stream SHALL discard any held result without an output transfer, and xfer_cnt SHALL NOT increment in that cycle.

Verification
REQ-034 Wrap test: W=16, N=5, sat_en=0, lane 0 a=16'hFFFF, b=16'h0002, other lanes 1+2 -> one cycle later, lane 0 = 16'h0001, ovf=5'b00001, other lanes = 3.
REQ-035 Saturation test: same operands with sat_en=1 -> lane 0 = 16'hFFFF, ovf=5'b00001, other lanes = 3.
REQ-036 Backpressure test: one input accepted, out_ready held 0 for 4 cycles -> outputs stable, in_ready=0 throughout; out_ready=1 -> one transfer, xfer_cnt=1.
REQ-037 Throughput test: in_valid=1 and out_ready=1 for 10 cycles with distinct operands -> 10 consecutive results in order, no bubbles, xfer_cnt=10.
REQ-038 Reset test: rst pulsed while out_valid=1 and out_ready=0 -> next cycle out_valid=0, sum_vec=0, xfer_cnt=0, and the dropped result is never seen at the output.
REQ-039 Counter wrap test: CW=4, 17 output transfers -> xfer_cnt=1.

Source files
------------

// File: rtl/matrix_add_pipe.sv
// -----------------------------------------------------------------------------
// matrix_add_pipe
//   N-lane element-wise adder with a single output register stage and a
//   valid/ready handshake on both sides. Each lane adds two W-bit unsigned
//   operands. The result is either the wrapped low W bits or, in saturate
//   mode, all-ones on carry. Bit k of ovf reports lane k's carry-out in both
//   modes. A CW-bit counter counts completed output transfers.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous active-high reset
//   in_valid   in   1     upstream presents an operand pair
//   in_ready   out  1     block accepts an operand pair this cycle
//   a_vec      in   N*W   operand A, lane k at [k*W +: W]
//   b_vec      in   N*W   operand B, same layout
//   sat_en     in   1     1 = saturate, 0 = wrap (sampled with operands)
//   out_valid  out  1     sum_vec / ovf hold a valid result
//   out_ready  in   1     downstream accepts the result this cycle
//   sum_vec    out  N*W   per-lane sums, same layout as operands
//   ovf        out  N     per-lane carry-out
//   xfer_cnt   out  CW    completed output transfers (wraps)
// -----------------------------------------------------------------------------
module matrix_add_pipe #(
  parameter int W  = 16,
  parameter int N  = 5,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a_vec,
  input  logic [N*W-1:0] b_vec,
  input  logic           sat_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] sum_vec,
  output logic [N-1:0]   ovf,
  output logic [CW-1:0]  xfer_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [N*W-1:0] r_sum;
  logic [N-1:0]   r_ovf;
  logic [CW-1:0]  r_xfer_cnt;

  logic           w_in_xfer;
  logic           w_out_xfer;
  logic [N*W-1:0] w_lane_res;
  logic [N-1:0]   w_carry;

  // The output register is free when empty, or when it is being drained
  // this very cycle; this gives back-to-back transfers with no bubble.
  assign out_valid  = (r_state == ST_FULL);
  assign in_ready   = (!out_valid || out_ready) && !rst;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  assign sum_vec  = r_sum;
  assign ovf      = r_ovf;
  assign xfer_cnt = r_xfer_cnt;

  // Independent lanes: each lane widens to W+1 bits so the carry never
  // leaks into the neighbouring lane.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [W:0] w_sum;
    assign w_sum = {1'b0, a_vec[k*W +: W]} + {1'b0, b_vec[k*W +: W]};
    assign w_carry[k] = w_sum[W];
    assign w_lane_res[k*W +: W] = (sat_en && w_sum[W]) ? {W{1'b1}} : w_sum[W-1:0];
  end

  // Next-state logic for the EMPTY/FULL control.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_next_state = ST_FULL;
        end else begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_xfer && !w_in_xfer) begin
          w_next_state = ST_EMPTY;
        end else begin
          w_next_state = ST_FULL;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Result register: loads only on an accepted input, so don't-care data
  // presented with in_valid low never disturbs the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= {(N*W){1'b0}};
      r_ovf <= {N{1'b0}};
    end else if (w_in_xfer) begin
      r_sum <= w_lane_res;
      r_ovf <= w_carry;
    end else begin
      r_sum <= r_sum;
      r_ovf <= r_ovf;
    end
  end

  // Output transfer counter; reset has priority so a result discarded by
  // reset is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= {CW{1'b0}};
    end else if (w_out_xfer) begin
      r_xfer_cnt <= r_xfer_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_xfer_cnt <= r_xfer_cnt;
    end
  end

endmodule

// File: tb/tb_matrix_add_pipe.sv
// -----------------------------------------------------------------------------
// tb_matrix_add_pipe
//   Drives directed and random traffic into two instances of matrix_add_pipe
//   (CW=16 and CW=4, sharing all inputs) and compares against a queue-based
//   reference of the expected result stream computed with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_matrix_add_pipe;
  localparam int W  = 16;
  localparam int N  = 5;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] a_vec;
  logic [N*W-1:0] b_vec;
  logic           sat_en;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] sum_vec;
  logic [N-1:0]   ovf;
  logic [CW-1:0]  xfer_cnt;

  logic           in_ready4;
  logic           out_valid4;
  logic [N*W-1:0] sum_vec4;
  logic [N-1:0]   ovf4;
  logic [3:0]     xfer_cnt4;

  matrix_add_pipe #(.W(W), .N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .sum_vec(sum_vec), .ovf(ovf), .xfer_cnt(xfer_cnt)
  );

  matrix_add_pipe #(.W(W), .N(N), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a_vec(a_vec), .b_vec(b_vec), .sat_en(sat_en), .out_valid(out_valid4),
    .out_ready(out_ready), .sum_vec(sum_vec4), .ovf(ovf4), .xfer_cnt(xfer_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] sum;
    logic [N-1:0]   ovf;
  } res_t;

  res_t        exp_q[$];
  int unsigned m_cnt;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: per-lane unsigned addition using integer arithmetic.
  function automatic res_t ref_add(input logic [N*W-1:0] a, input logic [N*W-1:0] b, input logic sat);
    res_t        r;
    int unsigned s;
    for (int k = 0; k < N; k++) begin
      s = int'(a[k*W +: W]) + int'(b[k*W +: W]);
      r.ovf[k] = (s >= (32'd1 << W));
      if (sat && r.ovf[k]) r.sum[k*W +: W] = {W{1'b1}};
      else                 r.sum[k*W +: W] = s[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
    return v;
  endfunction

  // One clock cycle: drive at negedge, check in_ready, advance model at the
  // posedge, then check registered outputs 1 time unit later.
  task automatic cycle(input logic iv, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                       input logic sat, input logic ordy, input logic r);
    logic exp_rdy, acc, outx;
    @(negedge clk);
    rst = r; in_valid = iv; a_vec = a; b_vec = b; sat_en = sat; out_ready = ordy;
    #1;
    exp_rdy = !r && ((exp_q.size() == 0) || ordy);
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("in_ready_cw4", 128'(in_ready4), 128'(exp_rdy));
    acc  = iv && exp_rdy;
    outx = !r && (exp_q.size() != 0) && ordy;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (outx) begin
        void'(exp_q.pop_front());
        m_cnt++;
      end
      if (acc) exp_q.push_back(ref_add(a, b, sat));
    end
    chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("sum_vec", 128'(sum_vec), 128'(exp_q[0].sum));
      chk("ovf", 128'(ovf), 128'(exp_q[0].ovf));
    end else if (r) begin
      chk("sum_vec_rst", 128'(sum_vec), 128'(0));
      chk("ovf_rst", 128'(ovf), 128'(0));
    end
    chk("xfer_cnt", 128'(xfer_cnt), 128'(m_cnt[CW-1:0]));
    chk("xfer_cnt_cw4", 128'(xfer_cnt4), 128'(m_cnt[3:0]));
  endtask

  logic [N*W-1:0] va, vb;
  logic [N*W-1:0] zero_v;

  initial begin
    n_checks = 0; n_fail = 0; m_cnt = 0;
    zero_v = '0;
    rst = 1'b1; in_valid = 1'b0; a_vec = '0; b_vec = '0; sat_en = 1'b0; out_ready = 1'b0;

    // Reset state, then first cycle out of reset must be ready.
    cycle(1'b1, rand_vec(), rand_vec(), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, rand_vec(), rand_vec(), 1'b1, 1'b1, 1'b1);
    cycle(1'b0, rand_vec(), rand_vec(), 1'b0, 1'b0, 1'b0);

    // Wrap and saturation directed vectors.
    va = {16'd1, 16'd1, 16'd1, 16'd1, 16'hFFFF};
    vb = {16'd2, 16'd2, 16'd2, 16'd2, 16'h0002};
    cycle(1'b1, va, vb, 1'b0, 1'b1, 1'b0);
    chk("wrap_sum", 128'(sum_vec), 128'(80'h0003_0003_0003_0003_0001));
    chk("wrap_ovf", 128'(ovf), 128'(5'b00001));
    cycle(1'b1, va, vb, 1'b1, 1'b1, 1'b0);
    chk("sat_sum", 128'(sum_vec), 128'(80'h0003_0003_0003_0003_FFFF));
    chk("sat_ovf", 128'(ovf), 128'(5'b00001));
    cycle(1'b0, zero_v, zero_v, 1'b0, 1'b1, 1'b0);

    // Backpressure: hold for 4 cycles with new inputs offered, then drain.
    cycle(1'b0, zero_v, zero_v, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, rand_vec(), rand_vec(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_vec(), rand_vec(), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, rand_vec(), rand_vec(), 1'b0, 1'b1, 1'b0);
    chk("bp_cnt", 128'(xfer_cnt), 128'(1));
    chk("bp_drained", 128'(out_valid), 128'(0));

    // Throughput: 10 back-to-back transfers.
    cycle(1'b0, zero_v, zero_v, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, rand_vec(), rand_vec(), i[0], 1'b1, 1'b0);
    cycle(1'b0, zero_v, zero_v, 1'b0, 1'b1, 1'b0);
    chk("tp_cnt", 128'(xfer_cnt), 128'(10));

    // Reset mid-stream while stalled: result discarded, no count.
    cycle(1'b1, rand_vec(), rand_vec(), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, zero_v, zero_v, 1'b0, 1'b1, 1'b1);
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_cnt", 128'(xfer_cnt), 128'(0));
    cycle(1'b0, zero_v, zero_v, 1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_vec(), rand_vec(), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end

    // Counter wrap on the CW=4 instance: 17 transfers.
    cycle(1'b0, zero_v, zero_v, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b1, rand_vec(), rand_vec(), 1'b0, 1'b1, 1'b0);
    cycle(1'b0, zero_v, zero_v, 1'b0, 1'b1, 1'b0);
    chk("wrap_cnt4", 128'(xfer_cnt4), 128'(1));
    chk("wrap_cnt16", 128'(xfer_cnt), 128'(17));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
